// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Decode-field / control-strobe bundle between sequencer and datapath.
//            MC_MEM_WAIT_EN adds the mem_ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             zero;
`ifdef MC_MEM_WAIT_EN
  logic             mem_ready;
`endif
  logic             pc_en;
  logic             ir_en;
  logic             RegWrite;
  logic             PCSrc;
  logic             ALUSrc;
  logic [4:0]       ALU_operation;
  logic             write;
  logic             MemtoReg;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct3, funct7_5, zero,
`ifdef MC_MEM_WAIT_EN
    input  mem_ready,
`endif
    output pc_en, ir_en, RegWrite, PCSrc, ALUSrc, ALU_operation,
           write, MemtoReg, state, halted, illegal, retired
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
`ifdef MC_MEM_WAIT_EN
    output mem_ready,
`endif
    input  pc_en, ir_en, RegWrite, PCSrc, ALUSrc, ALU_operation,
           write, MemtoReg, state, halted, illegal, retired
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset datapath.
//            Optional MEM wait states when MC_MEM_WAIT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_BR  = 7'b1100011;
  localparam logic [6:0] c_OP_SYS = 7'b1110011;

  localparam logic [4:0] c_ALU_ADD = 5'd0;
  localparam logic [4:0] c_ALU_SUB = 5'd1;
  localparam logic [4:0] c_ALU_AND = 5'd2;
  localparam logic [4:0] c_ALU_OR  = 5'd3;
  localparam logic [4:0] c_ALU_XOR = 5'd4;
  localparam logic [4:0] c_ALU_SLL = 5'd5;
  localparam logic [4:0] c_ALU_SRL = 5'd6;
  localparam logic [4:0] c_ALU_SRA = 5'd7;
  localparam logic [4:0] c_ALU_SLT = 5'd8;

  state_t           r_state, w_state_nxt;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic             r_funct7_5;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic       w_set_illegal;
  logic       w_retire;
  logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br;
  logic [4:0] w_aluop;
  logic       w_alusrc;
  logic       w_exec_bad;
  logic       w_mem_done;

  assign w_is_r   = (r_opcode == c_OP_R);
  assign w_is_i   = (r_opcode == c_OP_I);
  assign w_is_lw  = (r_opcode == c_OP_LW);
  assign w_is_sw  = (r_opcode == c_OP_SW);
  assign w_is_br  = (r_opcode == c_OP_BR);
  assign w_alusrc = w_is_i | w_is_lw | w_is_sw;

`ifdef MC_MEM_WAIT_EN
  assign w_mem_done = bus.mem_ready;
`else
  assign w_mem_done = 1'b1;
`endif

  // ALU op and legality from the fields captured at the end of DECODE
  always_comb begin
    w_aluop    = c_ALU_ADD;
    w_exec_bad = 1'b0;
    if (w_is_br) begin
      w_aluop    = c_ALU_SUB;
      w_exec_bad = (r_funct3[2:1] != 2'b00);
    end else if (w_is_r || w_is_i) begin
      case (r_funct3)
        3'b000:  w_aluop = (w_is_r && r_funct7_5) ? c_ALU_SUB : c_ALU_ADD;
        3'b111:  w_aluop = c_ALU_AND;
        3'b110:  w_aluop = c_ALU_OR;
        3'b100:  w_aluop = c_ALU_XOR;
        3'b001:  w_aluop = c_ALU_SLL;
        3'b101:  w_aluop = r_funct7_5 ? c_ALU_SRA : c_ALU_SRL;
        3'b010:  w_aluop = c_ALU_SLT;
        default: w_exec_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_set_illegal = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          c_OP_R, c_OP_I, c_OP_LW, c_OP_SW, c_OP_BR: w_state_nxt = S_EXEC;
          c_OP_SYS: w_state_nxt = S_HALT;
          default: begin
            w_state_nxt   = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (w_exec_bad) begin
          w_state_nxt   = S_HALT;
          w_set_illegal = 1'b1;
        end else if (w_is_br) begin
          w_state_nxt = S_FETCH;
          w_retire    = 1'b1;
        end else if (w_is_lw || w_is_sw) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (w_mem_done) begin
          w_state_nxt = w_is_sw ? S_FETCH : S_WB;
          w_retire    = w_is_sw;
        end
      end
      S_WB: begin
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      default:  w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7_5 <= 1'b0;
      r_illegal  <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) begin
        r_opcode   <= bus.opcode;
        r_funct3   <= bus.funct3;
        r_funct7_5 <= bus.funct7_5;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_retire)      r_retired <= r_retired + 1'b1;
    end
  end

  // Gating on reset drops every strobe the instant reset asserts
  always_comb begin
    bus.ir_en         = 1'b0;
    bus.pc_en         = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.PCSrc         = 1'b0;
    bus.ALUSrc        = 1'b0;
    bus.ALU_operation = c_ALU_ADD;
    bus.write         = 1'b0;
    bus.MemtoReg      = 1'b0;
    bus.halted        = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: bus.ir_en = 1'b1;
        S_EXEC: begin
          bus.ALUSrc        = w_alusrc;
          bus.ALU_operation = w_aluop;
          if (w_is_br && !w_exec_bad) begin
            bus.pc_en = 1'b1;
            bus.PCSrc = r_funct3[0] ? ~bus.zero : bus.zero;
          end
        end
        S_MEM: begin
          bus.ALUSrc        = w_alusrc;
          bus.ALU_operation = w_aluop;
          bus.write         = w_is_sw;
          bus.pc_en         = w_is_sw & w_mem_done;
        end
        S_WB: begin
          bus.ALUSrc        = w_alusrc;
          bus.ALU_operation = w_aluop;
          bus.RegWrite      = 1'b1;
          bus.pc_en         = 1'b1;
          bus.MemtoReg      = ~w_is_lw;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state   = r_state;
  assign bus.illegal = r_illegal;
  assign bus.retired = r_retired;

endmodule

`default_nettype wire
